// File: rtl/handshaking_pkg.sv
// Shared definitions for the handshaking master FIFO: output FSM state
// encodings and the width helper used to size pointers, level and counters.
package handshaking_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEND  = 2'd1,
    ST_STALL = 2'd2
  } state_e;

  // Bits needed to index 'value' items; never less than one bit.
  function automatic int clog2_w(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/handshaking_master_fifo_if.sv
// Producer/consumer handshake bundle for the handshaking master FIFO.
// The master modport is the FIFO side; slave is the surrounding environment.
interface handshaking_master_fifo_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  ready_in;

  modport master (
    input  in_data, in_valid, ready_in,
    output in_ready, data_out, valid_out
  );

  modport slave (
    output in_data, in_valid, ready_in,
    input  in_ready, data_out, valid_out
  );

endinterface

// File: rtl/hs_fifo_mem.sv
// Circular buffer for the handshaking master FIFO: storage array, wrapping
// read/write pointers and the registered occupancy count.
module hs_fifo_mem
  import handshaking_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_flush,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic [clog2_w(DEPTH):0] o_level
);

  localparam int PTR_W = clog2_w(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;

  // NOTE: the storage array has no reset; occupancy is tracked by r_level, so
  // stale words are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      // Power-of-two depth lets the pointers wrap by plain overflow.
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + LVL_W'(i_push) - LVL_W'(i_pop);
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_level = r_level;

endmodule

// File: rtl/handshaking_master_fifo.sv
// Handshaking master FIFO: buffers producer words, presents them to a consumer
// in order, and flags a consumer that stalls a valid word for TIMEOUT cycles.
module handshaking_master_fifo
  import handshaking_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  handshaking_master_fifo_if.master bus,
  input  logic                      flush,
  input  logic                      err_clr,
  output logic [clog2_w(DEPTH):0]   level,
  output logic                      timeout_err
);

  localparam int LVL_W = clog2_w(DEPTH) + 1;
  localparam int CNT_W = clog2_w(TIMEOUT + 1);
  localparam bit TO_EN = (TIMEOUT != 0);

  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);
  localparam logic [CNT_W-1:0] TO_VAL   = CNT_W'(TIMEOUT);

  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_nxt;
  logic             w_in_ready;
  logic             w_valid;
  logic             w_push;
  logic             w_pop;
  logic             w_stalling;

  state_e           r_state;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_err;

  hs_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (flush),
    .i_wdata (bus.in_data),
    .o_rdata (bus.data_out),
    .o_level (w_level)
  );

  // Both flags come straight from the registered level; a full buffer never
  // accepts a word, even when the consumer pops in the same cycle.
  assign w_in_ready = (w_level != FULL_LVL);
  assign w_valid    = (w_level != '0);
  assign w_push     = bus.in_valid & w_in_ready;
  assign w_pop      = w_valid & bus.ready_in;
  assign w_stalling = TO_EN && w_valid && !bus.ready_in;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_level_nxt = w_level;
    if (flush) begin
      w_level_nxt = '0;
    end else begin
      w_level_nxt = w_level + LVL_W'(w_push) - LVL_W'(w_pop);
    end
  end

  // The state follows the post-edge level and stall count, so STALL holds
  // exactly while the counter sits saturated at TIMEOUT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_IDLE;
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (err_clr) r_timeout_err <= 1'b0;

      if (w_level_nxt == '0) begin
        r_state     <= ST_IDLE;
        r_stall_cnt <= '0;
      end else if (w_pop) begin
        r_state     <= ST_SEND;
        r_stall_cnt <= '0;
      end else if (w_stalling && (r_stall_cnt < TO_VAL)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
        if (r_stall_cnt == TO_VAL - 1'b1) begin
          // Placed after the clear above so a same-cycle set takes priority.
          r_state       <= ST_STALL;
          r_timeout_err <= 1'b1;
        end else begin
          r_state <= ST_SEND;
        end
      end else if (r_state == ST_IDLE) begin
        r_state <= ST_SEND;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.valid_out = w_valid;
  assign level         = w_level;
  assign timeout_err   = r_timeout_err;

endmodule

// File: tb/tb_handshaking_master_fifo.sv
// Randomized scoreboard bench for handshaking_master_fifo: a queue-based
// reference model tracks contents and stall time; a monitor compares each cycle.
module tb_handshaking_master_fifo;
  import handshaking_pkg::*;

  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 4;
  localparam int TIMEOUT    = 8;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       err_clr;
  logic [2:0] level;
  logic       timeout_err;

  handshaking_master_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  handshaking_master_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .flush       (flush),
    .err_clr     (err_clr),
    .level       (level),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: buffer contents, consecutive stall cycles, sticky flag.
  logic [DATA_WIDTH-1:0] mdl_q[$];
  int                    mdl_run;
  bit                    mdl_err;

  always @(posedge clk or negedge rst) begin
    int sz;
    bit do_push, do_pop, set_err;
    if (!rst) begin
      mdl_q.delete();
      mdl_run = 0;
      mdl_err = 1'b0;
    end else begin
      sz      = mdl_q.size();
      do_push = bus.in_valid && (sz < DEPTH);
      do_pop  = (sz > 0) && bus.ready_in;
      set_err = 1'b0;
      if (flush) begin
        mdl_q.delete();
        mdl_run = 0;
      end else begin
        if (do_pop)  void'(mdl_q.pop_front());
        if (do_push) mdl_q.push_back(bus.in_data);
        if (do_pop || mdl_q.size() == 0) begin
          mdl_run = 0;
        end else if (sz > 0 && mdl_run < TIMEOUT) begin
          mdl_run++;
          if (mdl_run == TIMEOUT) set_err = 1'b1;
        end
      end
      if (set_err)      mdl_err = 1'b1;
      else if (err_clr) mdl_err = 1'b0;
    end
  end

  // Monitor: compare the DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready",    32'(bus.in_ready),  32'(mdl_q.size() != DEPTH));
      check("valid_out",   32'(bus.valid_out), 32'(mdl_q.size() != 0));
      check("level",       32'(level),         32'(mdl_q.size()));
      check("timeout_err", 32'(timeout_err),   32'(mdl_err));
      if (mdl_q.size() != 0) check("data_out", 32'(bus.data_out), 32'(mdl_q[0]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic r);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.ready_in = r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b0;
    flush   = 1'b0;
    err_clr = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_valid_out", 32'(bus.valid_out), 32'd0);
    check("rst_level",     32'(level),         32'd0);
    check("rst_err",       32'(timeout_err),   32'd0);
    repeat (2) tick();
    rst = 1'b1;

    // Single word, consumer ready: visible one cycle after the push.
    drive(1'b1, 8'h96, 1'b1);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    check("single_valid", 32'(bus.valid_out), 32'd1);
    check("single_data",  32'(bus.data_out),  32'h96);
    tick();
    check("single_level", 32'(level), 32'd0);

    // Fill with consumer stalled; fifth word refused; drain in order.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 8'(i * 8'h11), 1'b0);
      tick();
      if (i == 4) check("full_in_ready", 32'(bus.in_ready), 32'd0);
    end
    check("full_level", 32'(level), 32'd4);
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 1; i <= 4; i++) begin
      check("drain_data", 32'(bus.data_out), 32'(i * 8'h11));
      tick();
    end
    check("drain_level", 32'(level), 32'd0);

    // Full buffer then 12 cycles of simultaneous traffic across pointer wrap.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b0);
      tick();
    end
    for (int i = 4; i < 16; i++) begin
      drive(1'b1, 8'(8'h40 + i), 1'b1);
      tick();
    end
    check("stream_level", 32'(level), 32'd3);
    drive(1'b0, 8'h00, 1'b1);
    repeat (3) tick();
    check("stream_empty", 32'(level), 32'd0);

    // Stall timeout on one held word, then pop and clear.
    drive(1'b1, 8'h5A, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    repeat (7) tick();
    check("to_not_yet", 32'(timeout_err), 32'd0);
    tick();
    check("to_set",      32'(timeout_err),  32'd1);
    check("to_data",     32'(bus.data_out), 32'h5A);
    check("to_state",    32'(dut.r_state),  32'(ST_STALL));
    drive(1'b0, 8'h00, 1'b1);
    tick();
    check("to_popped",   32'(level),        32'd0);
    check("to_err_held", 32'(timeout_err),  32'd1);
    drive(1'b0, 8'h00, 1'b0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("to_cleared",  32'(timeout_err),  32'd0);
    check("to_idle",     32'(dut.r_state),  32'(ST_IDLE));

    // Flush beats a same-cycle push.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'(8'hA0 + i), 1'b0);
      tick();
    end
    check("pre_flush_level", 32'(level), 32'd3);
    drive(1'b1, 8'hAA, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    check("flush_level", 32'(level),         32'd0);
    check("flush_valid", 32'(bus.valid_out), 32'd0);
    tick();
    check("flush_discard", 32'(level), 32'd0);

    // Randomized traffic with varying consumer stall bias.
    for (int blk = 0; blk < 12; blk++) begin
      int rdy_pct;
      rdy_pct = (blk % 3 == 0) ? 10 : ((blk % 3 == 1) ? 50 : 90);
      for (int c = 0; c < 40; c++) begin
        drive(1'($urandom_range(0, 3) != 0), 8'($urandom),
              1'($urandom_range(0, 99) < rdy_pct));
        flush   = 1'($urandom_range(0, 47) == 0);
        err_clr = 1'($urandom_range(0, 15) == 0);
        tick();
      end
    end
    flush   = 1'b0;
    err_clr = 1'b0;

    // Asynchronous reset in the middle of a transfer.
    drive(1'b1, 8'h31, 1'b0);
    tick();
    drive(1'b1, 8'h32, 1'b0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_level",    32'(level),         32'd0);
    check("arst_valid",    32'(bus.valid_out), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready),  32'd1);
    check("arst_err",      32'(timeout_err),   32'd0);
    drive(1'b0, 8'h00, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, 8'h77, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b1);
    check("post_rst_valid", 32'(bus.valid_out), 32'd1);
    check("post_rst_data",  32'(bus.data_out),  32'h77);
    tick();
    check("post_rst_level", 32'(level), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
